mipi_csi2_tx_frame_ctl: RTL and testbench

Frame sequencer directly upstream of the CSI-2 TX stage. Consumes a 4-pixel RAW10 video AXI4-Stream (tuser[0] = frame start, tlast = line end) and re-emits it beat-for-beat. Generates the single-cycle frame_start/frame_end pulses and the per-frame param_wc for the TX stage. Enforces programmable FS, inter-line and FE blanking gaps so the packet/PHY stage gets its LP/HS turnaround time.

---
 rtl/mipi_csi2_tx_frame_ctl_pkg.sv | 23 ++
 rtl/mipi_csi2_tx_frame_ctl_gap_timer.sv | 27 ++
 rtl/mipi_csi2_tx_frame_ctl.sv | 200 ++++++++++++++++++++
 tb/tb_mipi_csi2_tx_frame_ctl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi2_tx_frame_ctl_pkg.sv
// Shared types and constants for the CSI-2 TX frame sequencer.
package mipi_csi2_tx_frame_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FS,
    FS_GAP,
    LINE,
    LINE_GAP,
    FE_WAIT,
    FE,
    FE_GAP
  } state_t;

  localparam int unsigned BYTES_PER_BEAT  = 5;
  localparam int unsigned PIXELS_PER_BEAT = 4;

  // Long-packet word count for one line; truncated to the 16-bit WC field.
  function automatic logic [15:0] beats_to_wc(input logic [15:0] beats);
    return 16'(beats * 16'(BYTES_PER_BEAT));
  endfunction

endpackage

// File: rtl/mipi_csi2_tx_frame_ctl_gap_timer.sv
// Loadable down-counter shared by the FS, inter-line and FE blanking gaps.
module mipi_csi2_tx_frame_ctl_gap_timer #(
  parameter int unsigned GAP_BITS = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                i_load,
  input  logic [GAP_BITS-1:0] i_load_val,
  input  logic                i_run,
  output logic                o_done
);

  logic [GAP_BITS-1:0] r_cnt;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - GAP_BITS'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/mipi_csi2_tx_frame_ctl.sv
// CSI-2 TX frame sequencer: forwards the RAW10 video stream and frames it with
// FS/FE pulses, per-frame word count and programmable blanking gaps.
module mipi_csi2_tx_frame_ctl
  import mipi_csi2_tx_frame_ctl_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 40,
  parameter int unsigned USER_BITS  = 1,
  parameter int unsigned WIDTH_BITS = 14,
  parameter int unsigned LINE_BITS  = 12,
  parameter int unsigned GAP_BITS   = 16
) (
  input  logic                  aresetn,
  input  logic                  aclk,
  input  logic [WIDTH_BITS-1:0] param_width,
  input  logic [LINE_BITS-1:0]  param_height,
  input  logic [GAP_BITS-1:0]   param_fs_gap,
  input  logic [GAP_BITS-1:0]   param_line_gap,
  input  logic [GAP_BITS-1:0]   param_fe_gap,
  input  logic [DATA_BITS-1:0]  s_tdata,
  input  logic [USER_BITS-1:0]  s_tuser,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_BITS-1:0]  m_tdata,
  output logic [USER_BITS-1:0]  m_tuser,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic [15:0]           param_wc,
  output logic                  busy,
  output logic                  err_sync,
  output logic                  err_len
);

  localparam logic [WIDTH_BITS-1:0] W_ONE = WIDTH_BITS'(1);
  localparam logic [LINE_BITS-1:0]  L_ONE = LINE_BITS'(1);

  state_t                r_state;
  state_t                w_next;
  logic [WIDTH_BITS-1:0] r_width_beats;
  logic [LINE_BITS-1:0]  r_height;
  logic [GAP_BITS-1:0]   r_line_gap;
  logic [GAP_BITS-1:0]   r_fe_gap;
  logic [WIDTH_BITS-1:0] r_beat_cnt;
  logic [LINE_BITS-1:0]  r_line_cnt;
  logic [DATA_BITS-1:0]  r_m_tdata;
  logic [USER_BITS-1:0]  r_m_tuser;
  logic                  r_m_tlast;
  logic                  r_m_tvalid;
  logic [15:0]           r_param_wc;
  logic                  r_err_sync;
  logic                  r_err_len;

  logic                  w_s_tready;
  logic                  w_accept;
  logic                  w_discard;
  logic                  w_line_done;
  logic                  w_last_line;
  logic                  w_first_beat;
  logic                  w_gap_load;
  logic [GAP_BITS-1:0]   w_gap_val;
  logic                  w_gap_run;
  logic                  w_gap_done;
  logic [LINE_BITS-1:0]  w_height_eff;

  assign w_accept     = (r_state == LINE) && s_tvalid && w_s_tready;
  assign w_discard    = (r_state == IDLE) && s_tvalid && !s_tuser[0];
  assign w_line_done  = w_accept && s_tlast;
  assign w_last_line  = ((r_line_cnt + L_ONE) == r_height);
  assign w_first_beat = (r_line_cnt == '0) && (r_beat_cnt == '0);
  assign w_height_eff = (param_height == '0) ? L_ONE : param_height;

  mipi_csi2_tx_frame_ctl_gap_timer #(
    .GAP_BITS(GAP_BITS)
  ) u_gap_timer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .i_load     (w_gap_load),
    .i_load_val (w_gap_val),
    .i_run      (w_gap_run),
    .o_done     (w_gap_done)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (s_tvalid && s_tuser[0]) w_next = FS;
      FS:       w_next = FS_GAP;
      FS_GAP:   if (w_gap_done) w_next = LINE;
      LINE:     if (w_line_done) w_next = w_last_line ? FE_WAIT : LINE_GAP;
      LINE_GAP: if (w_gap_done) w_next = LINE;
      FE_WAIT:  if (!r_m_tvalid) w_next = FE;
      FE:       w_next = FE_GAP;
      FE_GAP:   if (w_gap_done) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    w_s_tready  = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_val   = '0;
    w_gap_run   = 1'b0;
    case (r_state)
      IDLE: w_s_tready = s_tvalid && !s_tuser[0];
      FS: begin
        frame_start = 1'b1;
        w_gap_load  = 1'b1;
        w_gap_val   = param_fs_gap;
      end
      LINE: begin
        w_s_tready = !r_m_tvalid || m_tready;
        w_gap_load = w_line_done && !w_last_line;
        w_gap_val  = r_line_gap;
      end
      FE: begin
        frame_end  = 1'b1;
        w_gap_load = 1'b1;
        w_gap_val  = r_fe_gap;
      end
      FS_GAP, LINE_GAP, FE_GAP: w_gap_run = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_m_tdata  <= '0;
      r_m_tuser  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (w_accept) begin
      r_m_tdata  <= s_tdata;
      r_m_tuser  <= s_tuser;
      r_m_tlast  <= s_tlast;
      r_m_tvalid <= 1'b1;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Frame parameters are captured once in FS so mid-frame changes wait a frame.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_width_beats <= '0;
      r_height      <= '0;
      r_line_gap    <= '0;
      r_fe_gap      <= '0;
      r_param_wc    <= '0;
      r_beat_cnt    <= '0;
      r_line_cnt    <= '0;
      r_err_sync    <= 1'b0;
      r_err_len     <= 1'b0;
    end else begin
      if (r_state == FS) begin
        r_width_beats <= param_width >> $clog2(PIXELS_PER_BEAT);
        r_height      <= w_height_eff;
        r_line_gap    <= param_line_gap;
        r_fe_gap      <= param_fe_gap;
        r_param_wc    <= beats_to_wc(16'(param_width >> $clog2(PIXELS_PER_BEAT)));
        r_beat_cnt    <= '0;
        r_line_cnt    <= '0;
      end
      if (w_accept) begin
        if (s_tlast) begin
          if ((r_beat_cnt + W_ONE) != r_width_beats) r_err_len <= 1'b1;
          r_beat_cnt <= '0;
          r_line_cnt <= r_line_cnt + L_ONE;
        end else begin
          r_beat_cnt <= r_beat_cnt + W_ONE;
        end
        if (s_tuser[0] && !w_first_beat) r_err_sync <= 1'b1;
      end
      if (w_discard) r_err_sync <= 1'b1;
    end
  end

  assign s_tready = w_s_tready;
  assign m_tdata  = r_m_tdata;
  assign m_tuser  = r_m_tuser;
  assign m_tlast  = r_m_tlast;
  assign m_tvalid = r_m_tvalid;
  assign param_wc = r_param_wc;
  assign busy     = (r_state != IDLE);
  assign err_sync = r_err_sync;
  assign err_len  = r_err_len;

endmodule

// File: tb/tb_mipi_csi2_tx_frame_ctl.sv
// Directed bench for the CSI-2 TX frame sequencer.
module tb_mipi_csi2_tx_frame_ctl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [13:0] param_width;
  logic [11:0] param_height;
  logic [15:0] param_fs_gap;
  logic [15:0] param_line_gap;
  logic [15:0] param_fe_gap;
  logic [39:0] s_tdata;
  logic [0:0]  s_tuser;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [39:0] m_tdata;
  logic [0:0]  m_tuser;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic        frame_start;
  logic        frame_end;
  logic [15:0] param_wc;
  logic        busy;
  logic        err_sync;
  logic        err_len;

  int total = 0;
  int bad   = 0;

  mipi_csi2_tx_frame_ctl #(
    .DATA_BITS (40),
    .USER_BITS (1),
    .WIDTH_BITS(14),
    .LINE_BITS (12),
    .GAP_BITS  (16)
  ) dut (
    .aresetn       (aresetn),
    .aclk          (aclk),
    .param_width   (param_width),
    .param_height  (param_height),
    .param_fs_gap  (param_fs_gap),
    .param_line_gap(param_line_gap),
    .param_fe_gap  (param_fe_gap),
    .s_tdata       (s_tdata),
    .s_tuser       (s_tuser),
    .s_tlast       (s_tlast),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .m_tdata       (m_tdata),
    .m_tuser       (m_tuser),
    .m_tlast       (m_tlast),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .param_wc      (param_wc),
    .busy          (busy),
    .err_sync      (err_sync),
    .err_len       (err_len)
  );

  always #5 aclk = ~aclk;

  // Output-side backpressure: constant 1, or toggling every cycle when r_tog is set.
  logic r_tog = 1'b0;
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_tready = r_tog ? !m_tready : 1'b1;
    end
  end

  // Monitor; cleared whenever mon_epoch moves.
  int          mon_epoch = 0;
  int          seen_epoch = 0;
  int          cyc = 0;
  int          fs_cnt, fe_cnt, fs_cyc, fe_cyc, busy_fall_cyc, last_out_cyc;
  int          viol = 0;
  logic        prev_busy = 1'b0;
  int          acc_cyc[$];
  logic [41:0] out_q[$];
  logic [41:0] exp_q[$];

  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (seen_epoch != mon_epoch) begin
        seen_epoch = mon_epoch;
        fs_cnt = 0; fe_cnt = 0; fs_cyc = 0; fe_cyc = 0;
        busy_fall_cyc = 0; last_out_cyc = 0;
        acc_cyc.delete();
        out_q.delete();
      end
      if (s_tvalid && s_tready) acc_cyc.push_back(cyc);
      if (m_tvalid && m_tready) begin
        out_q.push_back({m_tuser, m_tlast, m_tdata});
        last_out_cyc = cyc;
      end
      if (frame_start) begin fs_cnt++; fs_cyc = cyc; end
      if (frame_end) begin fe_cnt++; fe_cyc = cyc; end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;
      if ((frame_start && m_tvalid) || (frame_end && m_tvalid) || (frame_start && frame_end)) viol++;
    end
  end

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_epoch++;
    exp_q.delete();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic set_params(input int w, input int h, input int g0, input int g1, input int g2);
    param_width    = 14'(w);
    param_height   = 12'(h);
    param_fs_gap   = 16'(g0);
    param_line_gap = 16'(g1);
    param_fe_gap   = 16'(g2);
  endtask

  task automatic send_beat(input logic [39:0] d, input logic u, input logic l);
    logic got;
    got = 1'b0;
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge aclk);
      got = s_tready;
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    if (!got) expect_eq("send_timeout", 64'(got), 64'(1));
  endtask

  task automatic send_frame(input int wb, input int lines, input int short_line, input logic [7:0] tag);
    int          bw;
    logic [39:0] d;
    logic        u, l;
    for (int ln = 0; ln < lines; ln++) begin
      bw = (ln == short_line) ? wb - 1 : wb;
      for (int b = 0; b < bw; b++) begin
        d = {tag, 8'(ln), 8'(b), 16'hA5C3};
        u = (ln == 0) && (b == 0);
        l = (b == bw - 1);
        exp_q.push_back({u, l, d});
        send_beat(d, u, l);
      end
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge aclk);
      done = !busy && !m_tvalid;
    end
    @(posedge aclk);
    #1;
    if (!done) expect_eq("idle_timeout", 64'(done), 64'(1));
  endtask

  task automatic check_out(input string tag);
    expect_eq({tag, "_nbeats"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < out_q.size()) expect_eq({tag, "_beat"}, 64'(out_q[i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    s_tdata = '0; s_tuser = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    set_params(16, 3, 4, 2, 3);
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    expect_eq("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    expect_eq("rst_busy", 64'(busy), 64'(0));
    expect_eq("rst_wc", 64'(param_wc), 64'(0));
    expect_eq("rst_errs", 64'({err_sync, err_len}), 64'(0));
    expect_eq("rst_pulses", 64'({frame_start, frame_end}), 64'(0));
    @(posedge aclk);
    #1;

    // Nominal frame: 16 px x 3 lines, gaps 4/2/3
    clear_mon();
    send_frame(4, 3, -1, 8'h11);
    wait_idle();
    expect_eq("t1_fs_cnt", 64'(fs_cnt), 64'(1));
    expect_eq("t1_fe_cnt", 64'(fe_cnt), 64'(1));
    expect_eq("t1_acc_cnt", 64'(acc_cyc.size()), 64'(12));
    expect_eq("t1_fs_gap", 64'(acc_cyc[0] - fs_cyc), 64'(6));
    expect_eq("t1_line_gap1", 64'(acc_cyc[4] - acc_cyc[3]), 64'(4));
    expect_eq("t1_line_gap2", 64'(acc_cyc[8] - acc_cyc[7]), 64'(4));
    expect_eq("t1_fe_after_drain", 64'(fe_cyc - last_out_cyc), 64'(2));
    expect_eq("t1_busy_fall", 64'(busy_fall_cyc - fe_cyc), 64'(5));
    expect_eq("t1_wc", 64'(param_wc), 64'(20));
    expect_eq("t1_errs", 64'({err_sync, err_len}), 64'(0));
    check_out("t1");

    // Same frame under toggling backpressure
    clear_mon();
    r_tog = 1'b1;
    send_frame(4, 3, -1, 8'h22);
    wait_idle();
    r_tog = 1'b0;
    expect_eq("t2_fe_cnt", 64'(fe_cnt), 64'(1));
    expect_eq("t2_fe_after_drain", 64'(fe_cyc - last_out_cyc), 64'(2));
    expect_eq("t2_errs", 64'({err_sync, err_len}), 64'(0));
    check_out("t2");

    // Junk beats in IDLE are dropped and flagged
    clear_mon();
    send_beat(40'hDEAD_0000_01, 1'b0, 1'b0);
    send_beat(40'hDEAD_0000_02, 1'b0, 1'b1);
    @(negedge aclk);
    expect_eq("t3_err_sync", 64'(err_sync), 64'(1));
    expect_eq("t3_busy_after_junk", 64'(busy), 64'(0));
    @(posedge aclk);
    #1;
    send_frame(4, 3, -1, 8'h33);
    wait_idle();
    expect_eq("t3_err_len", 64'(err_len), 64'(0));
    check_out("t3");

    // Short middle line
    do_reset();
    @(negedge aclk);
    expect_eq("t4_err_sync_clr", 64'(err_sync), 64'(0));
    @(posedge aclk);
    #1;
    clear_mon();
    send_frame(4, 3, 1, 8'h44);
    wait_idle();
    expect_eq("t4_err_len", 64'(err_len), 64'(1));
    expect_eq("t4_err_sync", 64'(err_sync), 64'(0));
    expect_eq("t4_fe_cnt", 64'(fe_cnt), 64'(1));
    check_out("t4");

    // Zero gaps, height 0 -> one line of 8 px
    do_reset();
    set_params(8, 0, 0, 0, 0);
    clear_mon();
    send_frame(2, 1, -1, 8'h55);
    wait_idle();
    expect_eq("t5_fs_gap", 64'(acc_cyc[0] - fs_cyc), 64'(2));
    expect_eq("t5_fe_after_drain", 64'(fe_cyc - last_out_cyc), 64'(2));
    expect_eq("t5_busy_fall", 64'(busy_fall_cyc - fe_cyc), 64'(2));
    expect_eq("t5_wc", 64'(param_wc), 64'(10));
    expect_eq("t5_fe_cnt", 64'(fe_cnt), 64'(1));
    check_out("t5");

    // Reset mid-line, then a clean frame
    set_params(16, 2, 1, 1, 1);
    send_beat({8'h77, 32'h0}, 1'b1, 1'b0);
    send_beat({8'h77, 32'h1}, 1'b0, 1'b0);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    expect_eq("t6_m_tvalid", 64'(m_tvalid), 64'(0));
    expect_eq("t6_busy", 64'(busy), 64'(0));
    expect_eq("t6_wc", 64'(param_wc), 64'(0));
    expect_eq("t6_pulses", 64'({frame_start, frame_end}), 64'(0));
    expect_eq("t6_errs", 64'({err_sync, err_len}), 64'(0));
    @(posedge aclk);
    #1;
    clear_mon();
    send_frame(4, 2, -1, 8'h66);
    wait_idle();
    expect_eq("t6_fs_cnt", 64'(fs_cnt), 64'(1));
    expect_eq("t6_fe_cnt", 64'(fe_cnt), 64'(1));
    expect_eq("t6_wc_new", 64'(param_wc), 64'(20));
    expect_eq("t6_errs_after", 64'({err_sync, err_len}), 64'(0));
    check_out("t6");

    expect_eq("pulse_overlap", 64'(viol), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
